// File: rtl/fft_stage_sched_if.sv
// rtl/fft_stage_sched_if.sv - control, RAM-port and butterfly handshake bundle for fft_stage_sched
//
// Purpose: groups every non-clock/reset signal of the FFT stage scheduler.
// master : the scheduler side (drives busy/done/stage, RAM read/write strobes and
//          addresses, butterfly enable and twiddle index, error flag).
// slave  : the environment side (drives start and bf_out_valid).
interface fft_stage_sched_if #(
    parameter int LOG2N = 6
);
    logic             start;
    logic             busy;
    logic             done;
    logic [LOG2N-1:0] stage;
    logic             rd_en;
    logic [LOG2N-1:0] rd_addr_a;
    logic [LOG2N-1:0] rd_addr_b;
    logic             bf_enable;
    logic [LOG2N-2:0] tw_idx;
    logic             bf_out_valid;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_a;
    logic [LOG2N-1:0] wr_addr_b;
    logic             err_unexpected;

    modport master (
        input  start, bf_out_valid,
        output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, bf_enable, tw_idx,
               wr_en, wr_addr_a, wr_addr_b, err_unexpected
    );

    modport slave (
        output start, bf_out_valid,
        input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, bf_enable, tw_idx,
               wr_en, wr_addr_a, wr_addr_b, err_unexpected
    );
endinterface

// File: rtl/fft_stage_sched.sv
// rtl/fft_stage_sched.sv - in-place radix-2 DIF FFT butterfly issue scheduler
//
// Purpose: walks all LOG2N stages of an N-point DIF FFT, issuing one butterfly
// per cycle (RAM read addresses, then butterfly enable + twiddle index) and
// writing results back to the addresses they were read from via an address FIFO.
// Each stage fully drains before the next one starts reading.
// Ports:
//   i_clk    : clock
//   i_reset  : asynchronous active-low reset
//   bus      : fft_stage_sched_if.master
//              start / busy / done / stage       - top-level control
//              rd_en / rd_addr_a / rd_addr_b     - sample RAM read (1-cycle latency)
//              bf_enable / tw_idx                - butterfly input valid + twiddle index
//              bf_out_valid                      - butterfly result valid
//              wr_en / wr_addr_a / wr_addr_b     - result write-back
//              err_unexpected                    - sticky: result with nothing outstanding
module fft_stage_sched #(
    parameter int N          = 64,
    parameter int LOG2N      = 6,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fft_stage_sched_if.master  bus
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int KW = LOG2N - 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [KW-1:0]       r_k;
    logic [LOG2N-1:0]    r_stage;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [2*LOG2N-1:0]  r_fifo [FIFO_DEPTH];
    logic                r_bf_enable;
    logic [KW-1:0]       r_tw_idx;
    logic                r_err;

    logic [PW-1:0]       w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_issue;
    logic                w_last_k;
    logic                w_last_stage;
    logic [LOG2N-1:0]    w_k_ext;
    logic [LOG2N-1:0]    w_span;
    logic [LOG2N-1:0]    w_mask;
    logic [LOG2N-1:0]    w_sh_hi;
    logic [LOG2N-1:0]    w_sh_lo;
    logic [LOG2N-1:0]    w_addr_a;
    logic [LOG2N-1:0]    w_addr_b;
    logic [KW-1:0]       w_tw;
    logic [2*LOG2N-1:0]  w_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == PW'(FIFO_DEPTH));
    assign w_pop   = bus.bf_out_valid && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO only stalls without one.
    assign w_issue = (r_state == S_ISSUE) && !(w_full && !w_pop);

    assign w_last_k     = (r_k == KW'(N/2 - 1));
    assign w_last_stage = (r_stage == LOG2N'(LOG2N - 1));

    // Butterfly k of stage s: block index k>>(LOG2N-1-s) scaled to block size
    // 2*span, plus offset k mod span; partner is span further on.
    assign w_k_ext  = {1'b0, r_k};
    assign w_span   = LOG2N'(N/2) >> r_stage;
    assign w_mask   = w_span - LOG2N'(1);
    assign w_sh_hi  = LOG2N'(LOG2N - 1) - r_stage;
    assign w_sh_lo  = LOG2N'(LOG2N) - r_stage;
    assign w_addr_a = ((w_k_ext >> w_sh_hi) << w_sh_lo) | (w_k_ext & w_mask);
    assign w_addr_b = w_addr_a + w_span;
    assign w_tw     = (r_k & w_mask[KW-1:0]) << r_stage;

    assign w_head = r_fifo[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_ISSUE;
            S_ISSUE: if (w_issue && w_last_k) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_empty) w_state_nxt = w_last_stage ? S_DONE : S_ISSUE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_k         <= '0;
            r_stage     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_bf_enable <= 1'b0;
            r_tw_idx    <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_k     <= '0;
                r_stage <= '0;
            end else if (w_issue) begin
                r_k <= w_last_k ? '0 : r_k + KW'(1);
            end else if (r_state == S_DRAIN && w_empty && !w_last_stage) begin
                r_stage <= r_stage + LOG2N'(1);
            end else if (r_state == S_DONE) begin
                r_stage <= '0;
            end
            if (w_issue) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
            r_bf_enable <= w_issue;
            r_tw_idx    <= w_issue ? w_tw : '0;
            if (bus.bf_out_valid && w_empty) r_err <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_issue) r_fifo[r_wr_ptr[AW-1:0]] <= {w_addr_a, w_addr_b};
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = (r_state == S_DONE);
    assign bus.stage          = r_stage;
    assign bus.rd_en          = w_issue;
    assign bus.rd_addr_a      = w_issue ? w_addr_a : '0;
    assign bus.rd_addr_b      = w_issue ? w_addr_b : '0;
    assign bus.bf_enable      = r_bf_enable;
    assign bus.tw_idx         = r_tw_idx;
    assign bus.wr_en          = w_pop;
    assign bus.wr_addr_a      = w_pop ? w_head[2*LOG2N-1:LOG2N] : '0;
    assign bus.wr_addr_b      = w_pop ? w_head[LOG2N-1:0] : '0;
    assign bus.err_unexpected = r_err;
endmodule

// File: tb/tb_fft_stage_sched.sv
// tb/tb_fft_stage_sched.sv - bench for fft_stage_sched (N=8; depth16/lat4 and depth4/lat10)
module tb_fft_stage_sched;
    localparam int NB = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fft_stage_sched_if #(.LOG2N(3)) bus0 ();
    fft_stage_sched_if #(.LOG2N(3)) bus1 ();

    fft_stage_sched #(.N(8), .LOG2N(3), .FIFO_DEPTH(16)) u_dut0 (.i_clk(clk), .i_reset(rst_n), .bus(bus0));
    fft_stage_sched #(.N(8), .LOG2N(3), .FIFO_DEPTH(4))  u_dut1 (.i_clk(clk), .i_reset(rst_n), .bus(bus1));

    logic       m_rd_en [2], m_bf_en [2], m_wr_en [2], m_done [2], m_busy [2], m_err [2], m_ov [2];
    logic [2:0] m_rd_a [2], m_rd_b [2], m_wr_a [2], m_wr_b [2], m_stage [2];
    logic [1:0] m_tw [2];

    assign m_rd_en[0] = bus0.rd_en;     assign m_rd_en[1] = bus1.rd_en;
    assign m_rd_a[0]  = bus0.rd_addr_a; assign m_rd_a[1]  = bus1.rd_addr_a;
    assign m_rd_b[0]  = bus0.rd_addr_b; assign m_rd_b[1]  = bus1.rd_addr_b;
    assign m_bf_en[0] = bus0.bf_enable; assign m_bf_en[1] = bus1.bf_enable;
    assign m_tw[0]    = bus0.tw_idx;    assign m_tw[1]    = bus1.tw_idx;
    assign m_wr_en[0] = bus0.wr_en;     assign m_wr_en[1] = bus1.wr_en;
    assign m_wr_a[0]  = bus0.wr_addr_a; assign m_wr_a[1]  = bus1.wr_addr_a;
    assign m_wr_b[0]  = bus0.wr_addr_b; assign m_wr_b[1]  = bus1.wr_addr_b;
    assign m_done[0]  = bus0.done;      assign m_done[1]  = bus1.done;
    assign m_busy[0]  = bus0.busy;      assign m_busy[1]  = bus1.busy;
    assign m_stage[0] = bus0.stage;     assign m_stage[1] = bus1.stage;
    assign m_err[0]   = bus0.err_unexpected; assign m_err[1] = bus1.err_unexpected;
    assign m_ov[0]    = bus0.bf_out_valid;   assign m_ov[1]   = bus1.bf_out_valid;

    int total = 0;
    int bad = 0;

    // Expected butterfly order: every stage pairs (i, i+span) for i with the span bit clear.
    int ea [NB], eb [NB], etw [NB], es [NB];
    int lit_a [NB]  = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int lit_b [NB]  = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int lit_tw [NB] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};

    int   fd [2]  = '{16, 4};
    int   lat [2] = '{4, 10};
    int   ridx [2], widx [2], done_cnt [2], tw_exp [2];
    logic tw_due [2], exp_err [2], prev_done [2];
    logic inj = 1'b0;
    logic [15:0] pipe [2];
    logic ov_drv [2];

    task automatic chk(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string name);
        for (int d = 0; d < 2; d++)
            chk(name, d, int'({m_rd_en[d], m_rd_a[d], m_rd_b[d], m_bf_en[d], m_tw[d], m_wr_en[d],
                               m_wr_a[d], m_wr_b[d], m_done[d], m_busy[d], m_stage[d], m_err[d]}), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk); #2;
        bus0.start = 1'b1; bus1.start = 1'b1;
        @(negedge clk); #2;
        bus0.start = 1'b0; bus1.start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (!(done_cnt[0] >= target && done_cnt[1] >= target) && n < 600) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, 0, done_cnt[0], target);
        chk(name, 1, done_cnt[1], target);
    endtask

    // Fixed-latency butterfly: result valid exactly lat cycles after bf_enable.
    initial begin
        pipe[0] = '0; pipe[1] = '0;
        bus0.bf_out_valid = 1'b0; bus1.bf_out_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    pipe[d]   = '0;
                    ov_drv[d] = 1'b0;
                end else begin
                    ov_drv[d] = pipe[d][lat[d]-1] | inj;
                    pipe[d]   = {pipe[d][14:0], m_bf_en[d]};
                end
            end
            bus0.bf_out_valid = ov_drv[0];
            bus1.bf_out_valid = ov_drv[1];
        end
    end

    // Per-cycle comparison of both DUTs against the ordered read/write model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int   r0, w0;
            logic ew, allow, mid;
            if (!rst_n) begin
                ridx[d] = 0; widx[d] = 0; tw_due[d] = 1'b0; exp_err[d] = 1'b0; prev_done[d] = 1'b0;
            end else begin
                r0    = ridx[d];
                w0    = widx[d];
                ew    = m_ov[d] && (w0 < r0);
                allow = ((r0 - w0) < fd[d]) || ew;
                mid   = (r0 % 4 != 0) && (r0 < NB);

                chk("wr_en", d, int'(m_wr_en[d]), int'(ew));
                if (ew && m_wr_en[d]) begin
                    chk("wr_addr", d, int'({m_wr_a[d], m_wr_b[d]}), ea[w0] * 8 + eb[w0]);
                    widx[d] = w0 + 1;
                end

                chk("bf_enable", d, int'(m_bf_en[d]), int'(tw_due[d]));
                if (tw_due[d]) chk("tw_idx", d, int'(m_tw[d]), tw_exp[d]);
                tw_due[d] = 1'b0;

                if (mid) chk("rd_flow", d, int'(m_rd_en[d]), int'(allow));
                if (m_rd_en[d]) begin
                    if (r0 >= NB) begin
                        chk("extra_read", d, r0, NB - 1);
                    end else begin
                        chk("rd_addr", d, int'({m_rd_a[d], m_rd_b[d]}), ea[r0] * 8 + eb[r0]);
                        chk("rd_stage", d, int'(m_stage[d]), es[r0]);
                        if (!mid) begin
                            chk("rd_not_full", d, int'(allow), 1);
                            chk("drain_before_read", d, w0, r0);
                        end
                        tw_due[d] = 1'b1;
                        tw_exp[d] = etw[r0];
                        ridx[d]   = r0 + 1;
                    end
                end
                if (m_rd_en[d] || m_wr_en[d]) chk("busy_active", d, int'(m_busy[d]), 1);

                chk("err", d, int'(m_err[d]), int'(exp_err[d]));
                if (m_ov[d] && w0 == r0) exp_err[d] = 1'b1;

                if (prev_done[d]) chk("busy_after_done", d, int'(m_busy[d]), 0);
                if (m_done[d]) begin
                    chk("done_all_written", d, ridx[d] * 100 + widx[d], NB * 100 + NB);
                    chk("busy_at_done", d, int'(m_busy[d]), 1);
                    done_cnt[d]++;
                    ridx[d] = 0;
                    widx[d] = 0;
                end
                prev_done[d] = m_done[d];
            end
        end
    end

    initial begin
        int i, n, span;
        bus0.start = 1'b0; bus1.start = 1'b0;
        done_cnt[0] = 0; done_cnt[1] = 0;

        i = 0;
        for (int s = 0; s < 3; s++) begin
            span = 8 >> (s + 1);
            for (int x = 0; x < 8; x++) begin
                if ((x & span) == 0) begin
                    ea[i] = x; eb[i] = x + span; etw[i] = ((x % span) << s) % 4; es[i] = s;
                    i++;
                end
            end
        end
        for (int j = 0; j < NB; j++)
            chk("model_pin", j, ea[j] * 100 + eb[j] * 10 + etw[j], lit_a[j] * 100 + lit_b[j] * 10 + lit_tw[j]);

        repeat (3) @(posedge clk);
        #2 check_zero("reset_state");
        @(negedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Stray result while idle.
        #2 inj = 1'b1;
        @(posedge clk); #3 inj = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("err_after_stray", 0, int'(m_err[0]), 1);
        chk("err_after_stray", 1, int'(m_err[1]), 1);

        // Run 1 with a second start while busy.
        pulse_start();
        repeat (5) @(negedge clk);
        #1 chk("busy_mid_run", 0, int'(m_busy[0]), 1);
        pulse_start();
        wait_done(1, "run1_done");
        repeat (30) @(negedge clk);
        #1;
        chk("done_once", 0, done_cnt[0], 1);
        chk("done_once", 1, done_cnt[1], 1);
        chk("err_held", 1, int'(m_err[1]), 1);

        // Run 2, aborted by reset during stage 1.
        pulse_start();
        n = 0;
        while (ridx[0] < 6 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reach_stage1", 0, int'(ridx[0] >= 6), 1);
        #1 rst_n = 1'b0;
        #1 check_zero("reset_mid_stage1");
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("no_done_on_abort", 0, done_cnt[0], 1);

        // Run 3 from a clean start.
        pulse_start();
        wait_done(2, "run3_done");
        repeat (3) @(negedge clk);
        #1;
        chk("err_cleared", 0, int'(m_err[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
